// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared types, sizes and helpers
// for the button/switch front end.
package input_conditioner_pkg;

    localparam int N_BTN = 3;
    localparam int N_SW  = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        REPEATING  = 2'd2
    } rep_state_t;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser plus stable-time filter
// for one active-high input bit.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DB_CYC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Two-stage synchroniser, reset to the inactive level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Accept a new level only after DB_CYC consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYC - 1)) begin
            level <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounced buttons/switches, press pulses,
// auto-repeat and sticky CPU-visible event flags.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_MS       = 150,
    parameter int REPEAT_EN       = 1,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_ack,
    output logic [N_SW-1:0]  sw_states,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_edit
);

    localparam int DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int RD_CYC = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
    localparam int RP_CYC = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam int R_MAX  = (RD_CYC > RP_CYC) ? RD_CYC : RP_CYC;
    localparam int RW     = $clog2(R_MAX + 1);

    if (DB_CYC < 1 || RD_CYC < 1 || RP_CYC < 1) begin : g_bad_cfg
        $error("input_conditioner: derived cycle counts must be >= 1");
    end

    logic [N_BTN-1:0] btn_cond;
    logic [N_BTN-1:0] lvl_q;
    logic [N_BTN-1:0] rep;

    // Internally a button reads 1 when pressed.
    assign btn_cond = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn_db
        debounce_bit #(.DB_CYC(DB_CYC)) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (btn_cond[i]),
            .level (btn_level[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw_db
        debounce_bit #(.DB_CYC(DB_CYC)) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (sw_raw[i]),
            .level (sw_states[i])
        );
    end

    // Previous debounced level, used to mark the first pressed cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= btn_level;
        end
    end

    assign btn_press = btn_level & ~lvl_q;

    if (REPEAT_EN != 0) begin : g_rep
        for (genvar i = 0; i < N_BTN; i++) begin : g_fsm
            rep_state_t    state;
            rep_state_t    state_n;
            logic [RW-1:0] rcnt;
            logic [RW-1:0] rcnt_n;
            logic          rep_i;

            // Repeat state and hold-time counter.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else begin
                    state <= state_n;
                    rcnt  <= rcnt_n;
                end
            end

            // Next state and repeat pulse; release always wins.
            always_comb begin
                state_n = state;
                rcnt_n  = rcnt;
                rep_i   = 1'b0;
                unique case (state)
                    IDLE: begin
                        if (btn_press[i]) begin
                            state_n = WAIT_FIRST;
                            rcnt_n  = '0;
                        end
                    end
                    WAIT_FIRST: begin
                        if (!btn_level[i]) begin
                            state_n = IDLE;
                            rcnt_n  = '0;
                        end else if (rcnt == RW'(RD_CYC - 1)) begin
                            rep_i   = 1'b1;
                            rcnt_n  = '0;
                            state_n = REPEATING;
                        end else begin
                            rcnt_n = rcnt + RW'(1);
                        end
                    end
                    REPEATING: begin
                        if (!btn_level[i]) begin
                            state_n = IDLE;
                            rcnt_n  = '0;
                        end else if (rcnt == RW'(RP_CYC - 1)) begin
                            rep_i  = 1'b1;
                            rcnt_n = '0;
                        end else begin
                            rcnt_n = rcnt + RW'(1);
                        end
                    end
                    default: begin
                        state_n = IDLE;
                        rcnt_n  = '0;
                    end
                endcase
            end

            assign rep[i] = rep_i;
        end
    end else begin : g_norep
        assign rep = '0;
    end

    // Sticky event flags: a new event in the ack cycle keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_edit <= '0;
        end else begin
            btn_edit <= (btn_edit & ~btn_ack) | btn_press | rep;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed checks of
// input_conditioner against a cycle-level behavioural model.
module tb_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic       clk;
    logic       reset;
    logic [2:0] btn_raw;
    logic [2:0] sw_raw;
    logic [2:0] btn_ack;
    logic [2:0] sw_states;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_edit;

    int tests;
    int fails;

    input_conditioner #(
        .CLK_HZ          (1000),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (20),
        .REPEAT_MS       (5),
        .REPEAT_EN       (1),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .btn_ack   (btn_ack),
        .sw_states (sw_states),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_edit  (btn_edit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Behavioural model: inputs are seen two edges late; a level
    // changes after DB consecutive differing samples; repeats occur
    // at RD, RD+RP, RD+2RP... cycles after the press cycle.
    bit [5:0]   pipe1;
    bit [5:0]   pipe2;
    bit [5:0]   mlv;
    bit [5:0]   nlv;
    int         run [6];
    int         hold [3];
    logic [2:0] m_press;
    logic [2:0] m_edit;
    bit         rep;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                pipe1   = '0;
                pipe2   = '0;
                mlv     = '0;
                m_press = '0;
                m_edit  = '0;
                for (int j = 0; j < 6; j++) run[j] = 0;
                for (int i = 0; i < 3; i++) hold[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    rep = mlv[i] && hold[i] >= RD &&
                          ((hold[i] - RD) % RP) == 0;
                    m_edit[i] = (m_edit[i] & ~btn_ack[i]) |
                                m_press[i] | rep;
                end
                nlv = mlv;
                for (int j = 0; j < 6; j++) begin
                    if (pipe2[j] != mlv[j]) run[j]++;
                    else run[j] = 0;
                    if (run[j] >= DB) begin
                        nlv[j] = pipe2[j];
                        run[j] = 0;
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    m_press[i] = nlv[i] & ~mlv[i];
                    if (m_press[i]) hold[i] = 0;
                    else if (nlv[i]) hold[i]++;
                    else hold[i] = 0;
                end
                mlv   = nlv;
                pipe2 = pipe1;
                pipe1 = {sw_raw, ~btn_raw};
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("sw_states", 64'(sw_states), 64'(mlv[5:3]));
                chk("btn_level", 64'(btn_level), 64'(mlv[2:0]));
                chk("btn_press", 64'(btn_press), 64'(m_press));
                chk("btn_edit",  64'(btn_edit),  64'(m_edit));
            end
        end
    end

    task automatic wait_press(input int idx, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!btn_press[idx] && n < 40);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int           n;
    bit           seen;
    logic [2:0]   e0;
    logic [63:0]  mask;
    int           tmr [6];

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        btn_raw = 3'b111;
        sw_raw  = 3'b000;
        btn_ack = 3'b000;
        idle(3);
        chk("reset_outputs", 64'({sw_states, btn_level, btn_press, btn_edit}),
            64'd0);
        reset = 1'b0;
        idle(4);

        // Single press, latency, sticky flag and ack.
        btn_raw[0] = 1'b0;
        wait_press(0, n);
        chk("press_latency", 64'(n), 64'd6);
        chk("press_level", 64'(btn_level[0]), 64'd1);
        @(posedge clk);
        #1;
        chk("press_one_cycle", 64'(btn_press[0]), 64'd0);
        chk("edit_set", 64'(btn_edit[0]), 64'd1);
        @(negedge clk);
        btn_ack = 3'b001;
        @(negedge clk);
        btn_ack = 3'b000;
        chk("edit_ack", 64'(btn_edit[0]), 64'd0);
        btn_raw[0] = 1'b1;
        idle(12);

        // Bouncing input never accepted, then a clean press.
        seen = 1'b0;
        for (int r = 0; r < 4; r++) begin
            btn_raw[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                seen = seen | btn_level[1] | btn_press[1];
            end
            btn_raw[1] = 1'b1;
            @(negedge clk);
            seen = seen | btn_level[1] | btn_press[1];
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen = seen | btn_level[1] | btn_press[1];
        end
        chk("glitch_no_press", 64'(seen), 64'd0);
        btn_raw[1] = 1'b0;
        wait_press(1, n);
        chk("bounce_final_latency", 64'(n), 64'd6);
        @(negedge clk);
        btn_raw[1] = 1'b1;
        idle(12);

        // Switches debounce alone and leave button outputs untouched.
        e0     = btn_edit;
        seen   = 1'b0;
        sw_raw = 3'b101;
        n      = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            seen = seen | (|btn_press);
        end while (sw_states != 3'b101 && n < 40);
        chk("sw_latency", 64'(n), 64'd6);
        chk("sw_no_press", 64'(seen), 64'd0);
        chk("sw_edit_same", 64'(btn_edit), 64'(e0));

        // Auto-repeat with continuous ack: set must win.
        do_reset();
        idle(3);
        btn_raw[2] = 1'b0;
        wait_press(2, n);
        btn_ack = 3'b100;
        mask    = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (btn_edit[2]) mask[k] = 1'b1;
        end
        chk("repeat_pattern", mask,
            (64'd1 << 1) | (64'd1 << 21) | (64'd1 << 26) |
            (64'd1 << 31) | (64'd1 << 36));
        @(negedge clk);
        btn_ack    = 3'b000;
        btn_raw[2] = 1'b1;
        idle(12);

        // Reset mid-debounce, button held through reset.
        btn_raw[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_mid_db", 64'({sw_states, btn_level, btn_press, btn_edit}),
            64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_press(0, n);
        chk("press_after_reset", 64'(n), 64'd6);
        repeat (25) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_repeating", 64'({sw_states, btn_level, btn_press, btn_edit}),
            64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_press(0, n);
        chk("press_after_reset2", 64'(n), 64'd6);
        @(negedge clk);
        btn_raw[0] = 1'b1;
        idle(12);

        // Simultaneous presses on buttons 0 and 2.
        do_reset();
        idle(3);
        btn_raw = 3'b010;
        wait_press(0, n);
        chk("dual_press", 64'(btn_press), 64'b101);
        @(posedge clk);
        #1;
        chk("dual_edit", 64'(btn_edit), 64'b101);
        btn_ack = 3'b001;
        @(posedge clk);
        #1;
        btn_ack = 3'b000;
        chk("dual_ack0", 64'(btn_edit), 64'b100);
        @(negedge clk);
        btn_raw = 3'b111;
        idle(12);

        // Randomized phase against the model.
        for (int j = 0; j < 6; j++) tmr[j] = $urandom_range(1, 40);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int j = 0; j < 6; j++) begin
                tmr[j]--;
                if (tmr[j] <= 0) begin
                    if (j < 3) btn_raw[j] = ~btn_raw[j];
                    else sw_raw[j-3] = ~sw_raw[j-3];
                    tmr[j] = ($urandom_range(0, 3) == 0) ?
                             $urandom_range(1, 5) : $urandom_range(6, 60);
                end
            end
            btn_ack = ($urandom_range(0, 3) == 0) ?
                      3'($urandom_range(0, 7)) : 3'b000;
            if (c == 1500) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        btn_ack = 3'b000;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Hardware front end that produces the button and switch words the CPU reads on its btn_edit and sw_states PIO inputs.
- Synchronises and debounces the 3 raw edit buttons and 3 mode switches.
- Generates one-cycle press pulses and auto-repeat pulses for held buttons.
- Holds a sticky per-button event flag until the CPU acknowledges it, so the polling firmware never misses a press.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
DEBOUNCE_MS, 10, required stable time before a level change is accepted
REPEAT_DELAY_MS, 500, hold time from press to first auto-repeat
REPEAT_MS, 150, auto-repeat period after the first repeat
REPEAT_EN, 1, 1 = auto-repeat enabled, 0 = press events only
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (board keys)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_raw  in  3  raw push buttons (asynchronous to clk)
sw_raw  in  3  raw slide switches (asynchronous to clk)
btn_ack  in  3  per-bit CPU clear of btn_edit; one-cycle pulse
sw_states  out  3  debounced switch levels (1 = on)
btn_level  out  3  debounced button levels, active-high (1 = pressed)
btn_press  out  3  one-cycle pulse on each debounced press
btn_edit  out  3  sticky event flags (press or repeat); feeds the CPU PIO

Behaviour:
- Derived constants:
  - DB_CYC = CLK_HZ/1000*DEBOUNCE_MS
  - RD_CYC = CLK_HZ/1000*REPEAT_DELAY_MS
  - RP_CYC = CLK_HZ/1000*REPEAT_MS
  - Counter widths = $clog2(max+1).
  - All constants must be >= 1; otherwise elaboration error.
- Polarity: button inputs are inverted when BTN_ACTIVE_LOW=1, before synchronisation. Internally, 1 always means pressed.
- Synchroniser: two flip-flops per input bit. Reset value is the inactive level, so no spurious event occurs after reset.
- Debounce, per bit (6 bits, independent):
  - Counter cnt holds 0 while sync == level.
  - While sync != level, cnt increments every cycle.
  - When cnt == DB_CYC-1 and sync still differs, level takes the sync value at the next edge and cnt returns to 0.
  - Any cycle with sync == level clears cnt (a glitch restarts the count).
  - Total latency from raw edge to level change: 2 + DB_CYC cycles.
- btn_press[i]: high for exactly the cycle in which btn_level[i] first reads 1. Registered alongside btn_level; no combinational path from inputs.
- Auto-repeat (REPEAT_EN=1), per button:
  - States: IDLE, WAIT_FIRST, REPEATING.
  - IDLE -> WAIT_FIRST on press; rcnt = 0.
  - WAIT_FIRST: rcnt counts; at rcnt == RD_CYC-1, emit a repeat pulse, rcnt = 0, go to REPEATING.
  - REPEATING: at rcnt == RP_CYC-1, emit a repeat pulse and rcnt = 0.
  - Debounced release in any state -> IDLE, rcnt = 0, no pulse in that cycle.
  - Repeat pulses do not drive btn_press; they only set btn_edit.
- btn_edit[i]:
  - Set on btn_press[i] or a repeat pulse.
  - Cleared on btn_ack[i].
  - Simultaneous set and ack: set wins (the flag stays 1).
  - Ack while the flag is 0 has no effect.
- Reset (asynchronous, any time): all outputs 0, all counters 0, FSMs to IDLE.
  - A button still held when reset deasserts is debounced normally and produces a press after 2 + DB_CYC cycles.
- Multiple buttons operate fully independently, including simultaneous presses.

Decomposition:
- Package input_conditioner_pkg holds:
  - repeat state enum (IDLE, WAIT_FIRST, REPEATING)
  - N_BTN = 3 and N_SW = 3
  - a function ms_to_cycles(clk_hz, ms)
- Sub-module debounce_bit holds: 2-flip-flop synchroniser, debounce counter and level register; parameter DB_CYC. It is instantiated 6 times.
- Repeat FSMs and sticky flags live in the top module.

Test Plan (CLK_HZ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_MS=5, BTN_ACTIVE_LOW=1):
1. btn_raw[0] 1->0 held -> btn_level[0]=1 and btn_press[0] pulses once, 6 cycles after the edge; btn_edit[0]=1 the next cycle. Ack pulse -> btn_edit[0]=0.
2. btn_raw[1] low for 3 cycles, high 1 cycle, low again, repeated -> btn_level[1] never rises and no press. A final steady low -> press 6 cycles after that last edge.
3. Hold btn_raw[2] low for 40 cycles after debounce -> repeat pulses at 20, 25, 30, 35 cycles after press. The ack issued each cycle in which a pulse occurs leaves btn_edit[2]=1 (set wins).
4. sw_raw=3'b101 -> sw_states=3'b101 after 6 cycles. No change on btn_edit/btn_press.
5. Assert reset mid-debounce (cnt=2) and during REPEATING -> all outputs 0 immediately. Button held through reset -> press at 6 cycles after reset release.
6. Press btn 0 and btn 2 in the same cycle -> both press pulses in the same cycle. Acking bit 0 only leaves btn_edit=3'b100.
